// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ req/ack producers.
// 1-cycle arbitration latency, bursts of up to MAX_BURST beats, stalls while fifo_full.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            grant,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          fifo_write_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BCW = $clog2(MAX_BURST + 1);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAX_BURST - 1);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDW-1:0]       gid_q, gid_d;
  logic [IDW-1:0]       rr_q, rr_d;
  logic [BCW-1:0]       beat_q, beat_d;

  logic                 xfer;
  logic                 release_burst;
  logic                 pick_vld;
  logic [IDW-1:0]       pick_id;
  logic [IDW:0]         cand;
  logic [DATA_WIDTH-1:0] sel_data;

  // Descending scan so the candidate closest to rr_q (smallest offset) wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = rr_q;
    cand     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NUM_REQ)) cand = cand - (IDW+1)'(NUM_REQ);
      if (req[cand[IDW-1:0]]) begin
        pick_vld = 1'b1;
        pick_id  = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gid_q == IDW'(i)) sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign xfer          = (state_q == GRANT) && req[gid_q] && !fifo_full;
  assign ack           = xfer ? grant_q : '0;
  assign fifo_write_en = xfer;
  assign fifo_data_in  = (state_q == GRANT) ? sel_data : '0;
  assign busy          = (state_q == GRANT);
  assign grant         = grant_q;
  assign grant_id      = gid_q;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    gid_d         = gid_q;
    rr_d          = rr_q;
    beat_d        = beat_q;
    release_burst = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d          = GRANT;
          gid_d            = pick_id;
          grant_d          = '0;
          grant_d[pick_id] = 1'b1;
          beat_d           = '0;
        end
      end
      GRANT: begin
        if (xfer) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) release_burst = 1'b1;
        end else if (!req[gid_q]) begin
          release_burst = 1'b1;
        end
        if (release_burst) begin
          state_d = IDLE;
          grant_d = '0;
          gid_d   = '0;
          rr_d    = (gid_q == LAST_ID) ? '0 : gid_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      gid_q   <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios plus constrained-random traffic vs a reference model.
module tb_fifo_write_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int B = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req = '1;
  logic [N*W-1:0] req_data = '0;
  logic           fifo_full = 1'b0;
  logic [N-1:0]   ack, grant;
  logic [1:0]     grant_id;
  logic           busy, fifo_write_en;
  logic [W-1:0]   fifo_data_in;

  int checks = 0;
  int errors = 0;

  // Reference model: current owner (-1 idle), round-robin start, beats in current burst.
  int m_own = -1;
  int m_rr = 0;
  int m_beats = 0;

  int wr_cnt = 0;
  int cur_len = 0;
  logic prev_busy = 1'b0;
  logic [N-1:0] last_ack = '0;
  int order_q[$];
  int len_q[$];

  fifo_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .MAX_BURST(B)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data),
    .ack(ack), .grant(grant), .grant_id(grant_id), .busy(busy),
    .fifo_write_en(fifo_write_en), .fifo_data_in(fifo_data_in), .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic bit m_xfer();
    return (m_own >= 0) && req[m_own] && !fifo_full;
  endfunction

  task automatic check_outputs();
    logic [N-1:0] eg, ea;
    logic [W-1:0] ed;
    eg = '0;
    ea = '0;
    ed = '0;
    if (m_own >= 0) begin
      eg[m_own] = 1'b1;
      ed = req_data[m_own*W +: W];
      if (m_xfer()) ea[m_own] = 1'b1;
    end
    chk("grant", grant, eg);
    chk("grant_id", grant_id, (m_own >= 0) ? m_own : 0);
    chk("busy", busy, m_own >= 0);
    chk("ack", ack, ea);
    chk("write_en", fifo_write_en, m_xfer());
    chk("data_in", fifo_data_in, ed);
  endtask

  task automatic model_clock();
    bit x;
    x = m_xfer();
    if (m_own < 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_own < 0 && req[(m_rr + k) % N]) begin
          m_own = (m_rr + k) % N;
          m_beats = 0;
        end
      end
    end else if (x) begin
      m_beats++;
      if (m_beats == B) begin
        m_rr = (m_own + 1) % N;
        m_own = -1;
      end
    end else if (!req[m_own]) begin
      m_rr = (m_own + 1) % N;
      m_own = -1;
    end
  endtask

  // Called at posedge+1: drive inputs, check mid-cycle, then advance the model on the edge.
  task automatic step(input logic [N-1:0] r, input logic [N*W-1:0] d, input logic f);
    req = r;
    req_data = d;
    fifo_full = f;
    @(negedge clk);
    check_outputs();
    last_ack = ack;
    if (fifo_write_en) wr_cnt++;
    if (busy && !prev_busy) order_q.push_back(int'(grant_id));
    if (!busy && prev_busy) begin
      len_q.push_back(cur_len);
      cur_len = 0;
    end
    if (busy && fifo_write_en) cur_len++;
    prev_busy = busy;
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_ack", ack, 0);
    chk("rst_write_en", fifo_write_en, 0);
    chk("rst_busy", busy, 0);
    m_own = -1;
    m_rr = 0;
    m_beats = 0;
    prev_busy = 1'b0;
    cur_len = 0;
    last_ack = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_grant", grant, 0);
    chk("rst_hold_write_en", fifo_write_en, 0);
    chk("rst_hold_grant_id", grant_id, 0);
    reset_n = 1'b1;
  endtask

  logic [N-1:0]   r;
  logic [N*W-1:0] d;

  initial begin
    // Reset held with every requester asking, then first grant goes to requester 0.
    do_reset();
    step(4'b1111, $urandom, 1'b0);
    chk("t1_first_grant", grant, 4'b0001);

    // Single requester, six beats: burst of four, bubble, regrant, two more.
    do_reset();
    wr_cnt = 0;
    for (int c = 0; c < 20 && wr_cnt < 6; c++) step(4'b0010, {N{8'hA5}}, 1'b0);
    repeat (2) step(4'b0000, '0, 1'b0);
    chk("t2_writes", wr_cnt, 6);

    // All requesting: service order 0,1,2,3,0 with full bursts.
    do_reset();
    order_q.delete();
    len_q.delete();
    for (int c = 0; c < 26; c++) step(4'b1111, {$urandom, 32'h0} >> 32, 1'b0);
    chk("t3_grants_seen", order_q.size() >= 5, 1);
    chk("t3_bursts_seen", len_q.size() >= 5, 1);
    for (int i = 0; i < 5 && i < order_q.size(); i++) chk($sformatf("t3_order%0d", i), order_q[i], i % N);
    for (int i = 0; i < 5 && i < len_q.size(); i++) chk($sformatf("t3_len%0d", i), len_q[i], B);

    // FIFO full for three cycles after beat 2: grant held, then beats 3-4, then release.
    do_reset();
    wr_cnt = 0;
    d = {N{8'h3C}};
    for (int c = 0; c < 10 && wr_cnt < 2; c++) step(4'b0100, d, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step(4'b0100, d, 1'b1);
      chk("t4_hold_grant", grant, 4'b0100);
    end
    chk("t4_writes_stalled", wr_cnt, 2);
    for (int c = 0; c < 10 && wr_cnt < 4; c++) step(4'b0100, d, 1'b0);
    chk("t4_released", grant, 4'b0000);

    // Requester 0 drops after two beats; requester 3 is next from rr_ptr=1.
    do_reset();
    wr_cnt = 0;
    for (int c = 0; c < 10 && wr_cnt < 2; c++) step(4'b1001, $urandom, 1'b0);
    step(4'b1000, $urandom, 1'b0);
    chk("t5_bubble", grant, 4'b0000);
    step(4'b1000, $urandom, 1'b0);
    chk("t5_grant", grant, 4'b1000);

    // Reset mid-burst on requester 2, then arbitration restarts from 0.
    do_reset();
    wr_cnt = 0;
    for (int c = 0; c < 10 && wr_cnt < 1; c++) step(4'b0100, $urandom, 1'b0);
    chk("t6_in_burst", grant, 4'b0100);
    req = 4'b0101;
    do_reset();
    step(4'b0101, $urandom, 1'b0);
    chk("t6_regrant", grant, 4'b0001);

    // Random traffic: requesters hold req/data until acked, may occasionally abandon.
    r = '0;
    d = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (r[i] && !last_ack[i]) begin
          if ($urandom_range(0, 19) == 0) r[i] = 1'b0;
        end else begin
          r[i] = ($urandom_range(0, 2) != 0);
          d[i*W +: W] = W'($urandom);
        end
      end
      step(r, d, $urandom_range(0, 4) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
Round-robin arbiter that shares one fifo write port among NUM_REQ requesters. Each requester presents data with a req/ack handshake. The arbiter grants one requester at a time for a burst of up to MAX_BURST beats and drives the FIFO's write_en/data_in. It honours the FIFO's full flag by stalling. It sits between producer blocks (UART RX, sensor samplers, debug taps) and a single shared fifo instance.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_WIDTH, 8, width of each requester's data and of the FIFO data
MAX_BURST, 4, max accepted beats per grant before forced rotation (>=1)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
req  input  NUM_REQ  per-requester request; bit i high = requester i has a beat ready
req_data  input  NUM_REQ*DATA_WIDTH  requester i data in bits [i*DATA_WIDTH +: DATA_WIDTH]
ack  output  NUM_REQ  one-hot, combinational; bit i high = requester i beat written this cycle
grant  output  NUM_REQ  registered one-hot grant, all-zero when idle
grant_id  output  $clog2(NUM_REQ)  registered index of granted requester, 0 when idle
busy  output  1  high while in GRANT state
fifo_write_en  output  1  to fifo write_en
fifo_data_in  output  DATA_WIDTH  to fifo data_in
fifo_full  input  1  from fifo full

Behaviour:
- Reset (async, reset_n low): state=IDLE, grant=0, grant_id=0, busy=0, rr_ptr=0, beat_cnt=0. Combinationally during reset: ack=0, fifo_write_en=0.
- States: IDLE, GRANT.
- IDLE: if any req bit set, select the first set bit searching from rr_ptr upward with wrap modulo NUM_REQ.
  - Register grant/grant_id and beat_cnt=0, then enter GRANT.
  - No write occurs in IDLE. First possible write is the cycle after req is seen: 1-cycle arbitration latency.
- GRANT, granted index g:
  - Transfer when req[g] && !fifo_full. fifo_write_en=1, fifo_data_in=req_data slice g, ack[g]=1, beat_cnt+1.
  - fifo_data_in = slice g whenever in GRANT, else 0.
  - fifo_full high: no transfer, ack=0, beat_cnt unchanged, grant held indefinitely.
  - Release when req[g] is low (no transfer that cycle), or when a transfer makes beat_cnt reach MAX_BURST.
  - On release: rr_ptr <= (g+1) mod NUM_REQ, grant=0, grant_id=0, state=IDLE. One bubble cycle always follows a release.
- Requester contract:
  - Hold req and data stable until ack.
  - Dropping req before ack abandons that beat without error.
  - Data is consumed only on the ack cycle.
- Requests from non-granted requesters are ignored until IDLE. They are never lost if held.
- beat_cnt width is $clog2(MAX_BURST+1). No overflow is possible.
- Never more than one ack bit high. fifo_write_en == |ack always.
- Reset mid-burst: grant is cleared immediately and the current beat is not written. After reset release, arbitration restarts from rr_ptr=0.
- Fairness: with all requesters continuously requesting and the FIFO never full, service order is 0,1,…,NUM_REQ-1,0…, each taking exactly MAX_BURST beats.

Test Plan:
1. Hold reset_n=0 with req=4'b1111 -> grant=0, ack=0, fifo_write_en=0, busy=0. Release -> grant=4'b0001 one cycle later.
2. req[1]=1 with data 0xA5 for 6 beats (N=4, W=8, B=4) -> grant=4'b0010 one cycle after req. Four writes of 0xA5, one idle cycle, regrant to 1, two more writes; 6 FIFO entries total.
3. req=4'b1111 continuously, FIFO never full -> grant sequence 0,1,2,3,0 with 4 writes each, separated by single idle cycles. Each ack bit pulses 4 times per round.
4. Requester 2 bursting, fifo_full high for 3 cycles after beat 2 -> fifo_write_en=0 and ack=0 for those 3 cycles, grant stays 4'b0100. Beats 3-4 are then written, followed by release.
5. Requester 0 drops req after 2 beats while req[3]=1 -> release after the drop, then a bubble, then grant=4'b1000 (rr_ptr=1, first set bit at or after 1 is 3).
6. reset_n pulsed low mid-burst on requester 2 -> outputs zero asynchronously, no write on that edge. After release with req=4'b0101 -> grant=4'b0001.
